// File: rtl/seq_divider8.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, results held
// from DONE until the next accepted Run.
module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH+1:0] diff;

  // Next-state and datapath: load on accept, one restoring step per COMPUTE cycle
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;

    a_sh = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    q_sh = {q_q[WIDTH-2:0], 1'b0};
    // Two extra zero bits keep the sign of the trial subtraction exact
    diff = {1'b0, a_sh} - {2'b00, d_q};

    case (state_q)
      IDLE: begin
        if (Run) begin
          a_d     = '0;
          q_d     = Dividend;
          d_d     = Divisor;
          dz_d    = (Divisor == {WIDTH{1'b0}});
          cnt_d   = '0;
          state_d = COMPUTE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        if (!diff[WIDTH+1]) begin
          a_d = diff[WIDTH:0];
          q_d = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          a_d = a_sh;
          q_d = q_sh;
        end
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (!Run) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign Quotient  = q_q;
  assign Remainder = a_q[WIDTH-1:0];
  assign Busy      = (state_q == COMPUTE);
  assign Done      = (state_q == DONE);
  assign DivZero   = dz_q;

endmodule

// File: tb/tb_seq_divider8.sv
// Directed, table-driven bench for seq_divider8 with hand-computed results and
// hand-written sequences for stability, mid-run reset and Run held in DONE.
module tb_seq_divider8;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs [7];

  seq_divider8 #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_quotient"},  32'(Quotient),  32'd0);
    check({tag, "_remainder"}, 32'(Remainder), 32'd0);
    check({tag, "_busy"},      32'(Busy),      32'd0);
    check({tag, "_done"},      32'(Done),      32'd0);
    check({tag, "_divzero"},   32'(DivZero),   32'd0);
  endtask

  // Full operation from IDLE: accept, 8 busy cycles, DONE, release Run, results hold
  task automatic run_op(input vec_t v, input string tag);
    Run      = 1'b1;
    Dividend = v.dvd;
    Divisor  = v.dvs;
    tick();
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"},    32'(Busy), 32'd1);
      check({tag, "_notdone"}, 32'(Done), 32'd0);
      tick();
    end
    check({tag, "_done"},      32'(Done),      32'd1);
    check({tag, "_busy_low"},  32'(Busy),      32'd0);
    check({tag, "_quotient"},  32'(Quotient),  32'(v.q));
    check({tag, "_remainder"}, 32'(Remainder), 32'(v.r));
    check({tag, "_divzero"},   32'(DivZero),   32'(v.dz));
    Run = 1'b0;
    tick();
    check({tag, "_done_fall"}, 32'(Done),      32'd0);
    check({tag, "_idle_busy"}, 32'(Busy),      32'd0);
    check({tag, "_q_hold"},    32'(Quotient),  32'(v.q));
    check({tag, "_r_hold"},    32'(Remainder), 32'(v.r));
    check({tag, "_dz_hold"},   32'(DivZero),   32'(v.dz));
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{dvd: 8'd200, dvs: 8'd7,   q: 8'd28,  r: 8'd4,   dz: 1'b0};
    vecs[1] = '{dvd: 8'd255, dvs: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0};
    vecs[2] = '{dvd: 8'd5,   dvs: 8'd9,   q: 8'd0,   r: 8'd5,   dz: 1'b0};
    vecs[3] = '{dvd: 8'd255, dvs: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0};
    vecs[4] = '{dvd: 8'd0,   dvs: 8'd3,   q: 8'd0,   r: 8'd0,   dz: 1'b0};
    vecs[5] = '{dvd: 8'd100, dvs: 8'd0,   q: 8'hFF,  r: 8'd100, dz: 1'b1};
    vecs[6] = '{dvd: 8'd9,   dvs: 8'd3,   q: 8'd3,   r: 8'd0,   dz: 1'b0};

    Reset    = 1'b1;
    Run      = 1'b0;
    Dividend = 8'd0;
    Divisor  = 8'd0;
    tick();
    tick();
    check_zero_outputs("reset");
    Reset = 1'b0;
    tick();
    check_zero_outputs("idle_after_reset");

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Operand changes and Run toggling during COMPUTE, then Run held through DONE
    Run      = 1'b1;
    Dividend = 8'd200;
    Divisor  = 8'd7;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("stab_busy", 32'(Busy), 32'd1);
      check("stab_notdone", 32'(Done), 32'd0);
      if (i == 2) begin
        Dividend = 8'd1;
        Divisor  = 8'd1;
      end
      Run = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    check("stab_done", 32'(Done), 32'd1);
    check("stab_quotient", 32'(Quotient), 32'd28);
    check("stab_remainder", 32'(Remainder), 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_done", 32'(Done), 32'd1);
      check("hold_no_restart", 32'(Busy), 32'd0);
      check("hold_quotient", 32'(Quotient), 32'd28);
      check("hold_remainder", 32'(Remainder), 32'd4);
    end
    Run = 1'b0;
    tick();
    check("drop_done", 32'(Done), 32'd0);
    check("drop_busy", 32'(Busy), 32'd0);
    v = '{dvd: 8'd17, dvs: 8'd5, q: 8'd3, r: 8'd2, dz: 1'b0};
    run_op(v, "after_hold");

    // Reset during the 4th COMPUTE cycle discards the partial result
    Run      = 1'b1;
    Dividend = 8'd200;
    Divisor  = 8'd7;
    tick();
    tick();
    tick();
    tick();
    check("pre_reset_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    Run   = 1'b0;
    tick();
    check_zero_outputs("midreset");
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midreset_no_done", 32'(Done), 32'd0);
    end
    v = '{dvd: 8'd50, dvs: 8'd6, q: 8'd8, r: 8'd2, dz: 1'b0};
    run_op(v, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider8.md
# seq_divider8

Sequential unsigned restoring divider for the arithmetic lab datapath. It runs the inverse operation of the add/shift multiplier: it repeatedly subtracts the divisor and produces one quotient bit per cycle. Operands are captured on a Run request. The quotient, remainder and divide-by-zero flag are then held stable until the next Run.

## Interface
- WIDTH, 8, operand/result width in bits; all values below assume 8.
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all state on the next rising edge
- Run  in  1  level request; sampled only in IDLE
- Dividend  in  WIDTH  unsigned numerator, captured when Run is accepted
- Divisor  in  WIDTH  unsigned denominator, captured when Run is accepted
- Quotient  out  WIDTH  result quotient; valid while Done=1, held afterwards
- Remainder  out  WIDTH  result remainder; valid while Done=1, held afterwards
- Busy  out  1  high in COMPUTE state
- Done  out  1  high in DONE state
- DivZero  out  1  captured Divisor==0; updated at start, held with results

## Operation
- Internal registers: A (WIDTH+1 bits, partial remainder), Q (WIDTH bits), D (WIDTH bits, captured divisor), cnt (3 bits).
- States and transitions:
  - IDLE: on Run=1, load A=0, Q=Dividend, D=Divisor, DivZero=(Divisor==0), cnt=0, then go to COMPUTE.
  - COMPUTE: perform one iteration per cycle. After the iteration with cnt=WIDTH-1, go to DONE; otherwise cnt++.
  - DONE: on Run=1, stay in DONE. On Run=0, go to IDLE.
- Iteration:
  - Shift {A,Q} left by 1, giving A' = {A[WIDTH-1:0], Q[WIDTH-1]} and Q' = {Q[WIDTH-2:0], 0}.
  - Compute diff = A' − {0,D} at WIDTH+2 bits, zero-extended, so the sign bit is exact.
  - If diff ≥ 0: A ← diff[WIDTH:0] and Q ← Q' | 1.
  - Otherwise: A ← A' (restore) and Q ← Q'.
- Outputs: Quotient = Q and Remainder = A[WIDTH-1:0]. After the final iteration A < D, so A[WIDTH] is 0.
- Divide by zero runs the full algorithm with no special path. The result is Quotient=8'hFF, Remainder=Dividend, DivZero=1.
- Changes on Dividend or Divisor after acceptance are ignored.
- Run during COMPUTE is ignored. No restart is possible until the block has passed through DONE and back to IDLE.
- Quotient and Remainder show intermediate values during COMPUTE. Consumers use them only while Done=1 or after Done falls.

## Timing
- Reset: on the next rising edge, state=IDLE, A=0, Q=0, D=0, cnt=0, DivZero=0, Busy=0, Done=0, Quotient=0, Remainder=0.
- Reset has priority over everything, including mid-COMPUTE and DONE. A partial result is discarded, with no further Done.
- Run accepted at edge k (Run=1, state IDLE): Busy=1 from k to k+8. Edges k+1..k+8 perform iterations 0..7.
- After edge k+8: Done=1, Busy=0, results final. Latency from accept to Done is 8 cycles.
- Done remains high as long as Run=1. At the first edge with Run=0 in DONE, state becomes IDLE and Done falls. Results hold.
- Minimum spacing between accepted Runs is 10 cycles: 1 accept, 8 compute, 1 DONE with Run low.
- Busy and Done are never high together. Both are decoded from state registers, with no combinational path from Run.

## Test plan
- Reset, then Run=1 with Dividend=200, Divisor=7, held until Done.
  - Expected: Busy high 8 cycles, then Done=1, Quotient=28, Remainder=4, DivZero=0.
  - Release Run: Done falls after one edge and the results hold.
- Corner operands:
  - 255/1 → Q=255, R=0.
  - 5/9 → Q=0, R=5.
  - 255/255 → Q=1, R=0.
  - 0/3 → Q=0, R=0.
- Dividend=100, Divisor=0 → Q=8'hFF, R=100, DivZero=1. A following 9/3 clears DivZero and gives Q=3, R=0.
- Operand stability: start 200/7, change the inputs to 1/1 during COMPUTE and toggle Run.
  - Expected: result still 28/4, with no restart while Busy.
- Reset mid-operation: assert Reset at the 4th COMPUTE cycle.
  - Expected: all outputs 0 next edge, state IDLE, no Done pulse.
  - A subsequent 50/6 gives Q=8, R=2 with normal 8-cycle latency.
- Run held high through DONE:
  - Expected: Done stays high and no second operation starts.
  - Drop Run for 1 cycle, then raise it with 17/5: accepted from IDLE, Q=3, R=2.
